// File: rtl/fica_pkg.sv
// Shared types and constants for the FastICA weight datapath.
package fica_pkg;

  localparam int W       = 26;
  localparam int FRAC    = 13;
  localparam int N       = 4;
  localparam int NELEM   = N * N;
  localparam int SUM_IDX = 16;

  typedef logic signed [W-1:0] fix_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    SUM
  } state_t;

endpackage

// File: rtl/w_sum16.sv
// Registered wrap-around adder tree over sixteen signed words.
// The sum is updated only when en is high; carries out of the top bit are
// dropped so the result is the modulo-2^W two's-complement sum.
module w_sum16 #(
  parameter int W = 26
) (
  input  logic                clk_s,
  input  logic                rst_s,
  input  logic                en,
  input  logic signed [W-1:0] din [16],
  output logic signed [W-1:0] sum
);

  logic signed [W-1:0] lvl1 [8];
  logic signed [W-1:0] lvl2 [4];
  logic signed [W-1:0] lvl3 [2];

  // Balanced pairwise reduction; each partial sum truncates to W bits.
  always_comb begin
    for (int i = 0; i < 8; i++) lvl1[i] = din[2*i] + din[2*i+1];
    for (int i = 0; i < 4; i++) lvl2[i] = lvl1[2*i] + lvl1[2*i+1];
    for (int i = 0; i < 2; i++) lvl3[i] = lvl2[2*i] + lvl2[2*i+1];
  end

  // Hold the checksum of the most recent snapshot.
  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      sum <= '0;
    end else if (en) begin
      sum <= lvl3[0] + lvl3[1];
    end
  end

endmodule

// File: rtl/w_matrix_serializer.sv
// Snapshots the 4x4 weight matrix on load_s and streams it row-major over a
// valid/ready handshake, optionally followed by a wrap-around checksum beat.
// All outputs are registered; the next beat is preloaded on each accept.
module w_matrix_serializer
  import fica_pkg::*;
#(
  parameter int W        = 26,
  parameter bit SEND_SUM = 1'b1
) (
  input  logic                clk_s,
  input  logic                rst_s,
  input  logic                load_s,
  input  logic signed [W-1:0] iw11,
  input  logic signed [W-1:0] iw12,
  input  logic signed [W-1:0] iw13,
  input  logic signed [W-1:0] iw14,
  input  logic signed [W-1:0] iw21,
  input  logic signed [W-1:0] iw22,
  input  logic signed [W-1:0] iw23,
  input  logic signed [W-1:0] iw24,
  input  logic signed [W-1:0] iw31,
  input  logic signed [W-1:0] iw32,
  input  logic signed [W-1:0] iw33,
  input  logic signed [W-1:0] iw34,
  input  logic signed [W-1:0] iw41,
  input  logic signed [W-1:0] iw42,
  input  logic signed [W-1:0] iw43,
  input  logic signed [W-1:0] iw44,
  output logic                busy,
  output logic                load_drop,
  output logic signed [W-1:0] o_data,
  output logic [4:0]          o_idx,
  output logic                o_valid,
  input  logic                o_ready,
  output logic                o_last,
  output logic                o_is_sum
);

  state_t              state;
  logic [3:0]          idx;
  logic [3:0]          idx_next;
  logic signed [W-1:0] in_words [16];
  logic signed [W-1:0] shadow   [16];
  logic signed [W-1:0] sum;
  logic                capture;

  assign in_words[0]  = iw11;
  assign in_words[1]  = iw12;
  assign in_words[2]  = iw13;
  assign in_words[3]  = iw14;
  assign in_words[4]  = iw21;
  assign in_words[5]  = iw22;
  assign in_words[6]  = iw23;
  assign in_words[7]  = iw24;
  assign in_words[8]  = iw31;
  assign in_words[9]  = iw32;
  assign in_words[10] = iw33;
  assign in_words[11] = iw34;
  assign in_words[12] = iw41;
  assign in_words[13] = iw42;
  assign in_words[14] = iw43;
  assign in_words[15] = iw44;

  assign capture  = (state == IDLE) && load_s;
  assign idx_next = idx + 4'd1;

  w_sum16 #(
    .W(W)
  ) u_sum (
    .clk_s(clk_s),
    .rst_s(rst_s),
    .en   (capture),
    .din  (in_words),
    .sum  (sum)
  );

  // Frame FSM: capture, per-beat advance on accept, optional checksum tail.
  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      state     <= IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      load_drop <= 1'b0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_idx     <= '0;
      o_last    <= 1'b0;
      o_is_sum  <= 1'b0;
      for (int i = 0; i < 16; i++) shadow[i] <= '0;
    end else begin
      load_drop <= load_s && busy;
      case (state)
        IDLE: begin
          if (load_s) begin
            for (int i = 0; i < 16; i++) shadow[i] <= in_words[i];
            state    <= SEND;
            idx      <= '0;
            busy     <= 1'b1;
            o_valid  <= 1'b1;
            o_data   <= in_words[0];
            o_idx    <= '0;
            o_last   <= 1'b0;
            o_is_sum <= 1'b0;
          end
        end
        SEND: begin
          if (o_ready) begin
            if (idx == 4'd15) begin
              idx <= '0;
              if (SEND_SUM) begin
                state    <= SUM;
                o_data   <= sum;
                o_idx    <= 5'(SUM_IDX);
                o_last   <= 1'b1;
                o_is_sum <= 1'b1;
              end else begin
                state    <= IDLE;
                busy     <= 1'b0;
                o_valid  <= 1'b0;
                o_data   <= '0;
                o_idx    <= '0;
                o_last   <= 1'b0;
                o_is_sum <= 1'b0;
              end
            end else begin
              idx    <= idx_next;
              o_data <= shadow[idx_next];
              o_idx  <= {1'b0, idx_next};
              o_last <= !SEND_SUM && (idx_next == 4'd15);
            end
          end
        end
        SUM: begin
          if (o_ready) begin
            state    <= IDLE;
            busy     <= 1'b0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_idx    <= '0;
            o_last   <= 1'b0;
            o_is_sum <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_w_matrix_serializer.sv
// Directed bench for w_matrix_serializer: checksum and 16-beat builds side by side.
module tb_w_matrix_serializer;

  logic        clk_s;
  logic        rst_s;
  logic        load_s;
  logic        o_ready;
  logic [25:0] vec  [16];
  logic [25:0] snap [16];
  logic [25:0] exp_sum;

  logic        busy, load_drop, o_valid, o_last, o_is_sum;
  logic [25:0] o_data;
  logic [4:0]  o_idx;

  logic        alt_busy, alt_load_drop, alt_valid, alt_last, alt_is_sum;
  logic [25:0] alt_data;
  logic [4:0]  alt_idx;

  int compare_count = 0;
  int fail_count    = 0;

  w_matrix_serializer #(.W(26), .SEND_SUM(1'b1)) dut (
    .clk_s(clk_s), .rst_s(rst_s), .load_s(load_s),
    .iw11(vec[0]),  .iw12(vec[1]),  .iw13(vec[2]),  .iw14(vec[3]),
    .iw21(vec[4]),  .iw22(vec[5]),  .iw23(vec[6]),  .iw24(vec[7]),
    .iw31(vec[8]),  .iw32(vec[9]),  .iw33(vec[10]), .iw34(vec[11]),
    .iw41(vec[12]), .iw42(vec[13]), .iw43(vec[14]), .iw44(vec[15]),
    .busy(busy), .load_drop(load_drop), .o_data(o_data), .o_idx(o_idx),
    .o_valid(o_valid), .o_ready(o_ready), .o_last(o_last), .o_is_sum(o_is_sum)
  );

  w_matrix_serializer #(.W(26), .SEND_SUM(1'b0)) dut_nosum (
    .clk_s(clk_s), .rst_s(rst_s), .load_s(load_s),
    .iw11(vec[0]),  .iw12(vec[1]),  .iw13(vec[2]),  .iw14(vec[3]),
    .iw21(vec[4]),  .iw22(vec[5]),  .iw23(vec[6]),  .iw24(vec[7]),
    .iw31(vec[8]),  .iw32(vec[9]),  .iw33(vec[10]), .iw34(vec[11]),
    .iw41(vec[12]), .iw42(vec[13]), .iw43(vec[14]), .iw44(vec[15]),
    .busy(alt_busy), .load_drop(alt_load_drop), .o_data(alt_data), .o_idx(alt_idx),
    .o_valid(alt_valid), .o_ready(o_ready), .o_last(alt_last), .o_is_sum(alt_is_sum)
  );

  // Free-running block clock.
  initial clk_s = 1'b0;
  always #5 clk_s = ~clk_s;

  // Hard stop in case the sequence itself stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compare_count++;
    if (obs !== expv) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic loadTable();
    vec[0]  = 26'h3FFFEC9; vec[1]  = 26'h0000400; vec[2]  = 26'h3FFF000; vec[3]  = 26'h0001234;
    vec[4]  = 26'h0000800; vec[5]  = 26'h0002AAA; vec[6]  = 26'h3FFFF00; vec[7]  = 26'h0000111;
    vec[8]  = 26'h0000222; vec[9]  = 26'h0000333; vec[10] = 26'h3FFE000; vec[11] = 26'h0000555;
    vec[12] = 26'h0000666; vec[13] = 26'h0000777; vec[14] = 26'h0000888; vec[15] = 26'h0000E1C;
  endtask

  function automatic logic [25:0] wrapSum();
    logic [25:0] s = '0;
    for (int i = 0; i < 16; i++) s = s + vec[i];
    return s;
  endfunction

  // Pulse load_s from idle and confirm beat 0 appears one edge later.
  task automatic applyStimulus(input logic [25:0] sum_exp);
    for (int i = 0; i < 16; i++) snap[i] = vec[i];
    exp_sum = sum_exp;
    load_s  = 1'b1;
    @(negedge clk_s);
    load_s  = 1'b0;
    checkOutput("startBusy",  busy,      1);
    checkOutput("startValid", o_valid,   1);
    checkOutput("startIdx",   o_idx,     0);
    checkOutput("startDrop",  load_drop, 0);
  endtask

  // Consume one frame beat by beat, optionally stalling and injecting loads.
  task automatic runFrame(input int stall_beat, input int stall_len, input int drop_beat,
                          input bit drop_at_end, input bit check_alt);
    int          exp_idx    = 0;
    int          stall_cnt  = 0;
    bit          prev_load  = 1'b0;
    bit          drop_done  = 1'b0;
    bit          rdy;
    logic [25:0] exp_data;
    for (int cyc = 0; cyc < 60; cyc++) begin
      checkOutput("loadDrop", load_drop, prev_load);
      load_s    = 1'b0;
      prev_load = 1'b0;
      if (!o_valid) break;
      exp_data = (exp_idx < 16) ? snap[exp_idx] : exp_sum;
      checkOutput("busy",  busy,     1);
      checkOutput("idx",   o_idx,    exp_idx);
      checkOutput("data",  o_data,   exp_data);
      checkOutput("last",  o_last,   exp_idx == 16);
      checkOutput("isSum", o_is_sum, exp_idx == 16);
      if (check_alt) begin
        if (exp_idx < 16) begin
          checkOutput("altValid", alt_valid,  1);
          checkOutput("altBusy",  alt_busy,   1);
          checkOutput("altIdx",   alt_idx,    exp_idx);
          checkOutput("altData",  alt_data,   snap[exp_idx]);
          checkOutput("altLast",  alt_last,   exp_idx == 15);
          checkOutput("altIsSum", alt_is_sum, 0);
          checkOutput("altDrop",  alt_load_drop, 0);
        end else begin
          checkOutput("altValidEnd", alt_valid, 0);
          checkOutput("altBusyEnd",  alt_busy,  0);
        end
      end
      rdy = 1'b1;
      if (exp_idx == stall_beat && stall_cnt < stall_len) begin
        rdy = 1'b0;
        stall_cnt++;
      end
      o_ready = rdy;
      if (exp_idx == drop_beat && !drop_done) begin
        load_s    = 1'b1;
        prev_load = 1'b1;
        drop_done = 1'b1;
        for (int i = 0; i < 16; i++) vec[i] = 26'h0000001;
      end
      if (drop_at_end && exp_idx == 16 && rdy) begin
        load_s    = 1'b1;
        prev_load = 1'b1;
      end
      @(posedge clk_s);
      if (rdy) exp_idx++;
      @(negedge clk_s);
    end
    o_ready = 1'b1;
    load_s  = 1'b0;
    checkOutput("frameLen", exp_idx, 17);
    checkOutput("busyEnd",  busy,    0);
  endtask

  initial begin
    rst_s   = 1'b1;
    load_s  = 1'b0;
    o_ready = 1'b1;
    for (int i = 0; i < 16; i++) vec[i] = '0;
    repeat (2) @(negedge clk_s);

    checkOutput("rstBusy",  busy,      0);
    checkOutput("rstDrop",  load_drop, 0);
    checkOutput("rstValid", o_valid,   0);
    checkOutput("rstData",  o_data,    0);
    checkOutput("rstIdx",   o_idx,     0);
    checkOutput("rstLast",  o_last,    0);
    checkOutput("rstIsSum", o_is_sum,  0);
    rst_s = 1'b0;
    @(negedge clk_s);
    checkOutput("idleValid", o_valid, 0);

    $display("[TB] full-rate frame with 16-beat build alongside");
    loadTable();
    applyStimulus(wrapSum());
    runFrame(-1, 0, -1, 1'b0, 1'b1);

    $display("[TB] backpressure at beat 5");
    applyStimulus(wrapSum());
    runFrame(5, 3, -1, 1'b0, 1'b0);

    $display("[TB] checksum overflow");
    for (int i = 0; i < 16; i++) vec[i] = 26'h1FFFFFF;
    applyStimulus(26'h3FFFFF0);
    runFrame(-1, 0, -1, 1'b0, 1'b0);

    $display("[TB] loads while busy");
    loadTable();
    applyStimulus(wrapSum());
    runFrame(-1, 0, 3, 1'b1, 1'b0);
    applyStimulus(26'h0000010);
    runFrame(-1, 0, -1, 1'b0, 1'b0);

    $display("[TB] reset mid-frame");
    loadTable();
    applyStimulus(wrapSum());
    for (int k = 0; k < 30 && o_idx != 5'd7; k++) @(negedge clk_s);
    checkOutput("preRstIdx", o_idx, 7);
    rst_s = 1'b1;
    @(negedge clk_s);
    checkOutput("midRstValid", o_valid,  0);
    checkOutput("midRstBusy",  busy,     0);
    checkOutput("midRstData",  o_data,   0);
    checkOutput("midRstIdx",   o_idx,    0);
    checkOutput("midRstLast",  o_last,   0);
    checkOutput("midRstIsSum", o_is_sum, 0);
    rst_s = 1'b0;
    @(negedge clk_s);
    checkOutput("postRstValid", o_valid, 0);
    applyStimulus(wrapSum());
    runFrame(-1, 0, -1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
